// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the N-channel cache-line memory arbiter.
// Holds the FSM state enum, parameter defaults and the owner-index width helper.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_IDX_W  = $clog2(DEF_NUM_CH);

  typedef logic [DEF_IDX_W-1:0] owner_idx_t;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_pick_n.sv
// Purpose: pick the first requesting channel after ptr, cyclically; returns one-hot grant and index.
// Latency: purely combinational, no state.
// Backpressure: none; callers mask ineligible requests before they reach req.
module arb_pick_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  // Search starts one past ptr, so ptr = NUM_CH-1 degenerates to lowest-index-wins.
  always_comb begin
    logic [IDX_W-1:0] c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      c = IDX_W'((int'(ptr) + off) % NUM_CH);
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// Purpose: grant one cache-line client per pmem burst, latch its command, route pmem_resp/rdata back.
// Latency: request seen in IDLE cycle t drives pmem_* at t+1; one IDLE cycle between bursts.
// Backpressure: clients hold requests until ch_resp; ARB_ROUND_ROBIN_EN selects rotating priority.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [NUM_CH*LINE_W-1:0] ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic [LINE_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp
);

  localparam int IDX_W = idx_w(NUM_CH);

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [NUM_CH-1:0] guard;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] win_gnt;
  logic              win_any;
  logic              load;
  logic              done;
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  // The channel just answered may still show its request for one cycle.
  assign req = (ch_read | ch_write) & ~guard;

  arb_pick_n #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_gnt[i]) begin
        sel_read  = sel_read  | ch_read[i];
        sel_write = sel_write | ch_write[i];
        sel_addr  = sel_addr  | ch_address[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | ch_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(NUM_CH - 1);
    end else if (load) begin
      ptr <= win_idx;
    end
  end
`else
  assign ptr = IDX_W'(NUM_CH - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    ch_resp   = '0;
    ch_rdata  = '0;
    case (state)
      IDLE: begin
        if (win_any) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (owner == IDX_W'(i)) begin
            ch_resp[i]                    = pmem_resp;
            ch_rdata[i*LINE_W +: LINE_W] = pmem_rdata;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      owner        <= '0;
      guard        <= '0;
    end else begin
      guard <= ch_resp;
      if (load) begin
        pmem_read    <= sel_read;
        pmem_write   <= sel_write;
        pmem_address <= sel_addr;
        pmem_wdata   <= sel_wdata;
        owner        <= win_idx;
      end else if (done) begin
        pmem_read  <= 1'b0;
        pmem_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n with three channels; inputs change and outputs are sampled on negedge.
module tb_mem_arbiter_n;

  localparam int NUM_CH = 3;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  localparam logic [LINE_W-1:0] RD1 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] RD2 = {32{8'h3C}};
  localparam logic [LINE_W-1:0] WD0 = {16{16'hBEEF}};
  localparam logic [LINE_W-1:0] WD1 = {16{16'h1234}};

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [NUM_CH*LINE_W-1:0] ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic                     pmem_read;
  logic                     pmem_write;
  logic [ADDR_W-1:0]        pmem_address;
  logic [LINE_W-1:0]        pmem_wdata;
  logic [LINE_W-1:0]        pmem_rdata;
  logic                     pmem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_n #(
    .NUM_CH (NUM_CH),
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_read      (ch_read),
    .ch_write     (ch_write),
    .ch_address   (ch_address),
    .ch_wdata     (ch_wdata),
    .ch_rdata     (ch_rdata),
    .ch_resp      (ch_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  task automatic idle_inputs();
    ch_read    = '0;
    ch_write   = '0;
    ch_address = '0;
    ch_wdata   = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read got=%b exp=0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL rst_pmem_write got=%b exp=0", pmem_write); end
    checks++; if (pmem_address !== '0) begin errors++; $display("FAIL rst_pmem_address got=%h exp=0", pmem_address); end
    checks++; if (pmem_wdata !== '0) begin errors++; $display("FAIL rst_pmem_wdata got=%h exp=0", pmem_wdata); end
    checks++; if (ch_resp !== 3'b000) begin errors++; $display("FAIL rst_ch_resp got=%b exp=000", ch_resp); end
    rst = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = RD1;
    #1;
    checks++; if (ch_resp !== 3'b000) begin errors++; $display("FAIL idle_resp_ignored got=%b exp=000", ch_resp); end
    checks++; if (ch_rdata !== '0) begin errors++; $display("FAIL idle_rdata_zero got=%h exp=0", ch_rdata); end
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL idle_no_burst got=%b exp=0", pmem_read); end
    idle_inputs();
  endtask

  task automatic test_single_read();
    @(negedge clk);
    ch_read[1] = 1'b1;
    ch_address[1*ADDR_W +: ADDR_W] = 32'h0000_0100;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL sr_pmem_read got=%b exp=1", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL sr_pmem_write got=%b exp=0", pmem_write); end
    checks++; if (pmem_address !== 32'h0000_0100) begin errors++; $display("FAIL sr_addr got=%h exp=00000100", pmem_address); end
    @(negedge clk);
    checks++; if (ch_resp !== 3'b000) begin errors++; $display("FAIL sr_no_early_resp got=%b exp=000", ch_resp); end
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = RD1;
    #1;
    checks++; if (ch_resp !== 3'b010) begin errors++; $display("FAIL sr_resp got=%b exp=010", ch_resp); end
    checks++; if (ch_rdata[1*LINE_W +: LINE_W] !== RD1) begin errors++; $display("FAIL sr_rdata1 got=%h exp=%h", ch_rdata[1*LINE_W +: LINE_W], RD1); end
    checks++; if (ch_rdata[0 +: LINE_W] !== '0) begin errors++; $display("FAIL sr_rdata0 got=%h exp=0", ch_rdata[0 +: LINE_W]); end
    @(negedge clk);
    pmem_resp  = 1'b0;
    ch_read[1] = 1'b0;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL sr_read_cleared got=%b exp=0", pmem_read); end
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL sr_stays_idle got=%b exp=0", pmem_read); end
  endtask

  task automatic test_contention();
    ch_write[0] = 1'b1;
    ch_address[0 +: ADDR_W] = 32'h0000_0200;
    ch_wdata[0 +: LINE_W] = WD0;
    ch_read[1] = 1'b1;
    ch_address[1*ADDR_W +: ADDR_W] = 32'h0000_0300;
    @(negedge clk);
    checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL ct_pmem_write got=%b exp=1", pmem_write); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL ct_pmem_read0 got=%b exp=0", pmem_read); end
    checks++; if (pmem_address !== 32'h0000_0200) begin errors++; $display("FAIL ct_addr0 got=%h exp=00000200", pmem_address); end
    checks++; if (pmem_wdata !== WD0) begin errors++; $display("FAIL ct_wdata0 got=%h exp=%h", pmem_wdata, WD0); end
    pmem_resp  = 1'b1;
    pmem_rdata = RD2;
    #1;
    checks++; if (ch_resp !== 3'b001) begin errors++; $display("FAIL ct_resp0 got=%b exp=001", ch_resp); end
    checks++; if (ch_rdata[1*LINE_W +: LINE_W] !== '0) begin errors++; $display("FAIL ct_rdata1_zero got=%h exp=0", ch_rdata[1*LINE_W +: LINE_W]); end
    @(negedge clk);
    pmem_resp   = 1'b0;
    ch_write[0] = 1'b0;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL ct_idle_gap got=%b exp=00", {pmem_read, pmem_write}); end
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL ct_pmem_read1 got=%b exp=1", pmem_read); end
    checks++; if (pmem_address !== 32'h0000_0300) begin errors++; $display("FAIL ct_addr1 got=%h exp=00000300", pmem_address); end
    pmem_resp = 1'b1;
    #1;
    checks++; if (ch_resp !== 3'b010) begin errors++; $display("FAIL ct_resp1 got=%b exp=010", ch_resp); end
    @(negedge clk);
    pmem_resp  = 1'b0;
    ch_read[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_guard();
    ch_read[0] = 1'b1;
    ch_address[0 +: ADDR_W] = 32'h0000_0600;
    @(negedge clk);
    checks++; if (pmem_address !== 32'h0000_0600) begin errors++; $display("FAIL gd_addr0 got=%h exp=00000600", pmem_address); end
    pmem_resp  = 1'b1;
    ch_read[1] = 1'b1;
    ch_address[1*ADDR_W +: ADDR_W] = 32'h0000_0700;
    #1;
    checks++; if (ch_resp !== 3'b001) begin errors++; $display("FAIL gd_resp0 got=%b exp=001", ch_resp); end
    @(negedge clk);
    pmem_resp = 1'b0;
    @(negedge clk);
    ch_read[0] = 1'b0;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL gd_pmem_read got=%b exp=1", pmem_read); end
    checks++; if (pmem_address !== 32'h0000_0700) begin errors++; $display("FAIL gd_ch1_wins got=%h exp=00000700", pmem_address); end
    pmem_resp = 1'b1;
    #1;
    checks++; if (ch_resp !== 3'b010) begin errors++; $display("FAIL gd_resp1 got=%b exp=010", ch_resp); end
    @(negedge clk);
    pmem_resp  = 1'b0;
    ch_read[1] = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL gd_no_reserve got=%b exp=0", pmem_read); end
  endtask

  task automatic test_latching();
    ch_read[0] = 1'b1;
    ch_address[0 +: ADDR_W] = 32'h0000_0400;
    ch_wdata[0 +: LINE_W] = WD0;
    @(negedge clk);
    checks++; if (pmem_address !== 32'h0000_0400) begin errors++; $display("FAIL lt_addr_first got=%h exp=00000400", pmem_address); end
    ch_address[0 +: ADDR_W] = 32'h0000_0500;
    ch_wdata[0 +: LINE_W] = WD1;
    ch_read[0] = 1'b0;
    @(negedge clk);
    checks++; if (pmem_address !== 32'h0000_0400) begin errors++; $display("FAIL lt_addr_held got=%h exp=00000400", pmem_address); end
    checks++; if (pmem_wdata !== WD0) begin errors++; $display("FAIL lt_wdata_held got=%h exp=%h", pmem_wdata, WD0); end
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL lt_no_abort got=%b exp=1", pmem_read); end
    pmem_resp  = 1'b1;
    pmem_rdata = RD2;
    #1;
    checks++; if (ch_resp !== 3'b001) begin errors++; $display("FAIL lt_resp got=%b exp=001", ch_resp); end
    checks++; if (ch_rdata[0 +: LINE_W] !== RD2) begin errors++; $display("FAIL lt_rdata0 got=%h exp=%h", ch_rdata[0 +: LINE_W], RD2); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    ch_read[1] = 1'b1;
    ch_address[1*ADDR_W +: ADDR_W] = 32'h0000_0800;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL ar_busy got=%b exp=1", pmem_read); end
    pmem_resp = 1'b1;
    #1;
    checks++; if (ch_resp !== 3'b010) begin errors++; $display("FAIL ar_resp_pre got=%b exp=010", ch_resp); end
    #1 rst = 1'b1;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL ar_read_cleared got=%b exp=0", pmem_read); end
    checks++; if (ch_resp !== 3'b000) begin errors++; $display("FAIL ar_resp_cleared got=%b exp=000", ch_resp); end
    checks++; if (pmem_address !== '0) begin errors++; $display("FAIL ar_addr_cleared got=%h exp=0", pmem_address); end
    pmem_resp = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL ar_rearb_read got=%b exp=1", pmem_read); end
    checks++; if (pmem_address !== 32'h0000_0800) begin errors++; $display("FAIL ar_rearb_addr got=%h exp=00000800", pmem_address); end
    pmem_resp = 1'b1;
    #1;
    checks++; if (ch_resp !== 3'b010) begin errors++; $display("FAIL ar_resp_post got=%b exp=010", ch_resp); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  // All channels request continuously; rotating priority serves 0,1,2,... while
  // fixed priority alternates 0,1 because only the guard displaces channel 0.
  task automatic test_back_to_back();
    int               exp_ch;
    logic [NUM_CH-1:0] exp_resp;
    logic [ADDR_W-1:0] exp_addr;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_read[i] = 1'b1;
      ch_address[i*ADDR_W +: ADDR_W] = 32'h0000_1000 + 32'(i) * 32'h100;
    end
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ch = k % 3;
`else
      exp_ch = k % 2;
`endif
      exp_resp = '0;
      exp_resp[exp_ch] = 1'b1;
      exp_addr = 32'h0000_1000 + 32'(exp_ch) * 32'h100;
      @(negedge clk);
      checks++; if (pmem_address !== exp_addr) begin errors++; $display("FAIL bb_addr[%0d] got=%h exp=%h", k, pmem_address, exp_addr); end
      pmem_resp = 1'b1;
      #1;
      checks++; if (ch_resp !== exp_resp) begin errors++; $display("FAIL bb_resp[%0d] got=%b exp=%b", k, ch_resp, exp_resp); end
      @(negedge clk);
      pmem_resp = 1'b0;
      checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL bb_gap[%0d] got=%b exp=0", k, pmem_read); end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_guard();
    test_latching();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
